text_dump: RTL and testbench
============================

# text_dump

Reads the full character RAM back out over the UART transmitter, one row at a time, and appends a line terminator after each row. It is the readback counterpart of the UART-to-RAM write path. It shares the same RAM geometry (row-major, `ram_addr = row * NUM_COLS + col`), so a host can capture the current screen contents. It sits between the character RAM's second read port and the UART TX byte interface.

## Interface
- `RAM_BITS`, 13: width of the RAM address.
- `NUM_COLS`, 80: characters per row.
- `NUM_ROWS`, 80: rows per screen; `NUM_ROWS*NUM_COLS` must be ≤ 2^RAM_BITS.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to dump the screen; accepted only when `busy` is low.
- `ram_addr`  out  RAM_BITS  RAM read address.
- `ram_rd_en`  out  1  read enable; RAM returns `ram_rdata` one cycle later.
- `ram_rdata`  in  8  RAM read data, valid the cycle after `ram_rd_en`.
- `uart_tx_data`  out  8  byte to transmit; stable while `uart_tx_stb` is high.
- `uart_tx_stb`  out  1  one-cycle transmit strobe.
- `uart_tx_busy`  in  1  transmitter busy; it is high from the cycle after an accepted strobe until the byte is sent.
- `busy`  out  1  dump in progress.
- `done`  out  1  one-cycle pulse when the dump completes.

## Operation
- **States:** S_IDLE, S_READ, S_WAIT, S_SEND, S_GAP, S_EOL, S_DONE (plus S_CR, see Configuration).
- **S_IDLE:** on `start`, clear `row`, `col` and `ram_addr`, then go to S_READ. `start` is ignored in every other state.
- **S_READ:** assert `ram_rd_en` with `ram_addr`, then go to S_WAIT.
- **S_WAIT:** latch `ram_rdata` into the tx byte, then go to S_SEND.
  - A `0x00` byte is substituted with `0x20`.
  - All other bytes are sent verbatim, including `0x0a`.
- **S_SEND:** hold while `uart_tx_busy` is high. When it is low, pulse `uart_tx_stb` for one cycle with `uart_tx_data` = the latched byte, then go to S_GAP.
- **S_GAP:** a one-cycle mandatory gap with the strobe low. Then:
  - if `col < NUM_COLS-1`: `col += 1`, `ram_addr += 1`, go to S_READ;
  - else: `col = 0`, go to S_EOL (or S_CR if configured).
- **S_EOL:** send `0x0a` using the same busy/strobe rule as S_SEND, followed by its own one-cycle gap. Then:
  - if `row < NUM_ROWS-1`: `row += 1`, `ram_addr += 1`, go to S_READ;
  - else go to S_DONE.
- **S_DONE:** pulse `done` for one cycle, then go to S_IDLE.
- **Address invariant:** outside S_IDLE, `ram_addr == row*NUM_COLS + col` at all times. It is maintained by increment only, with no multiplier.
- **Byte count:** total bytes per dump is `NUM_ROWS*(NUM_COLS+1)`, i.e. 6480 at the default parameters.

## Timing
- **Reset values:** `ram_addr=0`, `ram_rd_en=0`, `uart_tx_data=0`, `uart_tx_stb=0`, `busy=0`, `done=0`; state is S_IDLE.
- **Reset mid-dump:** everything returns to the reset values on the next edge. No further strobes are issued and `done` does not pulse.
- **Start latency:** `start` in cycle 0 gives `busy` = 1 and `ram_rd_en` = 1 with address 0 in cycle 1. The first `uart_tx_stb` comes no earlier than cycle 3.
- **Throughput:** with `uart_tx_busy` held low, one byte every 4 cycles: READ, WAIT, SEND, GAP.
- **Strobe spacing:** `uart_tx_stb` is never high in two consecutive cycles. It is never asserted while `uart_tx_busy` is high.
- **End of dump:** `busy` stays high through the final gap cycle. `done` pulses in the following cycle, with `busy` already low.
- **Busy at start:** if `uart_tx_busy` is high on entry to S_SEND, the block waits indefinitely. There is no timeout.

## Configuration
- **Macro:** `TEXT_DUMP_CRLF_EN`.
- **Defined:** at row end the block sends `0x0d` (state S_CR, with strobe and gap) and then `0x0a`. Total bytes per dump is `NUM_ROWS*(NUM_COLS+2)`, i.e. 6560 at the default parameters.
- **Not defined:** only `0x0a` is sent, and S_CR does not exist.

## Test plan
- **Full dump, LF only:** RAM filled with `addr[7:0]`, `uart_tx_busy` always low, `start` pulsed. Expect:
  - exactly 6480 strobes;
  - byte 81 (index 80) is `0x0a`;
  - byte 82 equals `RAM[80]`;
  - `done` pulses exactly once, in the cycle after the last gap.
- **Zero substitution:** `RAM[0]=0x00`, `RAM[1]=0x41` → first two bytes sent are `0x20`, `0x41`.
- **Backpressure:** `uart_tx_busy` held high for 10 cycles after every strobe → no strobe is asserted while busy is high, and no strobe occurs in adjacent cycles.
- **Reset and ignored start:** `rst` in the middle of row 3 → all outputs 0 on the next edge and no `done` pulse. A `start` issued while `busy` is high is ignored.
- **CRLF build:** with `TEXT_DUMP_CRLF_EN` defined → 6560 strobes, and bytes 81–82 are `0x0d`, `0x0a`.

Source files
------------

// File: rtl/text_dump_if.sv
// RAM read-port and UART TX byte bus between text_dump (master) and its peers.
interface text_dump_if #(
    parameter int unsigned RAM_BITS = 13
) ();
    logic [RAM_BITS-1:0] ram_addr;
    logic                ram_rd_en;
    logic [7:0]          ram_rdata;
    logic [7:0]          uart_tx_data;
    logic                uart_tx_stb;
    logic                uart_tx_busy;

    modport master (
        output ram_addr, ram_rd_en, uart_tx_data, uart_tx_stb,
        input  ram_rdata, uart_tx_busy
    );

    modport slave (
        input  ram_addr, ram_rd_en, uart_tx_data, uart_tx_stb,
        output ram_rdata, uart_tx_busy
    );
endinterface

// File: rtl/text_dump.sv
// Streams the character RAM out over UART row by row, with a line terminator per row.
// Optional: define TEXT_DUMP_CRLF_EN to send 0x0d before each 0x0a.
module text_dump #(
    parameter int unsigned RAM_BITS = 13,
    parameter int unsigned NUM_COLS = 80,
    parameter int unsigned NUM_ROWS = 80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    text_dump_if.master bus
);
    localparam int unsigned COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int unsigned ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
        S_GAP,
`ifdef TEXT_DUMP_CRLF_EN
        S_CR,
        S_CR_GAP,
`endif
        S_EOL,
        S_EOL_GAP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [RAM_BITS-1:0] addr_q, addr_d;
    logic [7:0]          tx_q, tx_d;
    logic                rd_en_q, rd_en_d;
    logic                stb_q, stb_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                col_last, row_last, tx_state_d;

    assign col_last = (col_q == COL_W'(NUM_COLS - 1));
    assign row_last = (row_q == ROW_W'(NUM_ROWS - 1));

    assign bus.ram_addr     = addr_q;
    assign bus.ram_rd_en    = rd_en_q;
    assign bus.uart_tx_data = tx_q;
    assign bus.uart_tx_stb  = stb_q;
    assign busy             = busy_q;
    assign done             = done_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Transmit states leave once their strobe has been issued
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_READ;
            S_READ:    state_d = S_WAIT;
            S_WAIT:    state_d = S_SEND;
            S_SEND:    if (stb_q) state_d = S_GAP;
`ifdef TEXT_DUMP_CRLF_EN
            S_GAP:     state_d = col_last ? S_CR : S_READ;
            S_CR:      if (stb_q) state_d = S_CR_GAP;
            S_CR_GAP:  state_d = S_EOL;
`else
            S_GAP:     state_d = col_last ? S_EOL : S_READ;
`endif
            S_EOL:     if (stb_q) state_d = S_EOL_GAP;
            S_EOL_GAP: state_d = row_last ? S_DONE : S_READ;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

`ifdef TEXT_DUMP_CRLF_EN
    assign tx_state_d = (state_d == S_SEND) || (state_d == S_CR) || (state_d == S_EOL);
`else
    assign tx_state_d = (state_d == S_SEND) || (state_d == S_EOL);
`endif

    // Registered outputs are computed from the state being entered
    always_comb begin
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d  = (state_d == S_DONE);
        rd_en_d = (state_d == S_READ);
        stb_d   = tx_state_d && !stb_q && !bus.uart_tx_busy;
        tx_d    = tx_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    col_d  = '0;
                    row_d  = '0;
                    addr_d = '0;
                end
            end
            S_WAIT: tx_d = (bus.ram_rdata == 8'h00) ? 8'h20 : bus.ram_rdata;
            S_GAP: begin
                if (!col_last) begin
                    col_d  = col_q + COL_W'(1);
                    addr_d = addr_q + RAM_BITS'(1);
                end else begin
                    col_d  = '0;
                end
            end
            S_EOL_GAP: begin
                if (!row_last) begin
                    row_d  = row_q + ROW_W'(1);
                    addr_d = addr_q + RAM_BITS'(1);
                end
            end
            default: ;
        endcase
`ifdef TEXT_DUMP_CRLF_EN
        if (state_d == S_CR && state_q != S_CR) tx_d = 8'h0d;
`endif
        if (state_d == S_EOL && state_q != S_EOL) tx_d = 8'h0a;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            tx_q    <= '0;
            rd_en_q <= 1'b0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            tx_q    <= tx_d;
            rd_en_q <= rd_en_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_text_dump.sv
// Self-checking bench for text_dump: RAM and UART models plus an expected byte stream.
module tb_text_dump;
    localparam int unsigned RAM_BITS = 13;
    localparam int unsigned NUM_COLS = 80;
    localparam int unsigned NUM_ROWS = 80;
`ifdef TEXT_DUMP_CRLF_EN
    localparam int unsigned LPL = NUM_COLS + 2;
`else
    localparam int unsigned LPL = NUM_COLS + 1;
`endif
    localparam int unsigned TOTAL = NUM_ROWS * LPL;

    typedef struct packed {
        logic [7:0] ram;
        logic [7:0] tx;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    text_dump_if #(.RAM_BITS(RAM_BITS)) bus ();

    text_dump #(
        .RAM_BITS(RAM_BITS),
        .NUM_COLS(NUM_COLS),
        .NUM_ROWS(NUM_ROWS)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .busy (busy),
        .done (done),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:(1<<RAM_BITS)-1];
    int cyc = 0;
    int bcnt = 0;
    int hold = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.ram_rd_en) bus.ram_rdata <= mem[bus.ram_addr];
    end

    // UART model: busy for `hold` cycles after each accepted strobe
    always @(posedge clk) begin
        if (bus.uart_tx_stb) bcnt <= hold;
        else if (bcnt != 0)  bcnt <= bcnt - 1;
    end
    assign bus.uart_tx_busy = (bcnt != 0);

    logic [7:0] got [$];
    int         stb_cyc [$];
    logic [7:0] expq [$];
    int busy_viol = 0, adj_viol = 0, done_cnt = 0, done_cyc = 0, done_busy = 0;
    logic prev_stb = 1'b0;

    always @(negedge clk) begin
        if (bus.uart_tx_stb === 1'b1) begin
            got.push_back(bus.uart_tx_data);
            stb_cyc.push_back(cyc);
            if (bus.uart_tx_busy) busy_viol = busy_viol + 1;
            if (prev_stb)         adj_viol  = adj_viol + 1;
        end
        prev_stb = (bus.uart_tx_stb === 1'b1);
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            if (busy !== 1'b0) done_busy = done_busy + 1;
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int getb(input int i);
        if (i < got.size()) return int'(got[i]);
        return -1;
    endfunction

    // Expected stream straight from the screen contents: each row, then its terminator
    task automatic build_exp();
        logic [7:0] b;
        expq.delete();
        for (int r = 0; r < int'(NUM_ROWS); r++) begin
            for (int c = 0; c < int'(NUM_COLS); c++) begin
                b = mem[r * NUM_COLS + c];
                expq.push_back((b == 8'h00) ? 8'h20 : b);
            end
`ifdef TEXT_DUMP_CRLF_EN
            expq.push_back(8'h0d);
`endif
            expq.push_back(8'h0a);
        end
    endtask

    function automatic int stream_mism(input int n);
        int m = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= got.size() || got[i] !== expq[i]) m++;
        end
        return m;
    endfunction

    task automatic wait_bytes(input string name, input int n, input int budget);
        int k = 0;
        while (got.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(name, int'(got.size() >= n), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ram_addr"},  int'(bus.ram_addr),     0);
        check({tag, "_ram_rd_en"}, int'(bus.ram_rd_en),    0);
        check({tag, "_tx_data"},   int'(bus.uart_tx_data), 0);
        check({tag, "_tx_stb"},    int'(bus.uart_tx_stb),  0);
        check({tag, "_busy"},      int'(busy),             0);
        check({tag, "_done"},      int'(done),             0);
    endtask

    vec_t tbl [8];
    int cyc0, d0, n_rst, k;

    initial begin
        tbl[0] = '{ram: 8'h00, tx: 8'h20};
        tbl[1] = '{ram: 8'h41, tx: 8'h41};
        tbl[2] = '{ram: 8'h0a, tx: 8'h0a};
        tbl[3] = '{ram: 8'h20, tx: 8'h20};
        tbl[4] = '{ram: 8'hff, tx: 8'hff};
        tbl[5] = '{ram: 8'h0d, tx: 8'h0d};
        tbl[6] = '{ram: 8'h00, tx: 8'h20};
        tbl[7] = '{ram: 8'h7e, tx: 8'h7e};

        rst   = 1'b1;
        start = 1'b0;
        hold  = 0;
        for (int i = 0; i < (1 << RAM_BITS); i++) mem[i] = 8'(i);
        for (int i = 0; i < 8; i++) mem[i] = tbl[i].ram;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_all_zero("reset");

        // Full dump, UART never busy
        build_exp();
        got.delete();
        stb_cyc.delete();
        start = 1'b1;
        cyc0  = cyc;
        tick();
        start = 1'b0;
        check("start_busy",  int'(busy),          1);
        check("start_rd_en", int'(bus.ram_rd_en), 1);
        check("start_addr",  int'(bus.ram_addr),  0);
        k = 0;
        while (done_cnt < 1 && k < 30000) begin
            tick();
            k++;
        end
        repeat (5) tick();
        check("full_done_count", done_cnt, 1);
        check("full_strobes", got.size(), TOTAL);
        check("full_stream_mismatches", stream_mism(TOTAL), 0);
        for (int i = 0; i < 8; i++) check($sformatf("subst[%0d]", i), getb(i), int'(tbl[i].tx));
`ifdef TEXT_DUMP_CRLF_EN
        check("row0_cr", getb(NUM_COLS),     8'h0d);
        check("row0_lf", getb(NUM_COLS + 1), 8'h0a);
`else
        check("row0_lf", getb(NUM_COLS), 8'h0a);
`endif
        check("row1_first", getb(LPL), 8'h50);
        if (stb_cyc.size() >= 2) begin
            check("first_stb_not_before_cycle3", int'(stb_cyc[0] - cyc0 >= 3), 1);
            check("throughput", stb_cyc[1] - stb_cyc[0], 4);
            check("done_after_last_gap", done_cyc - stb_cyc[stb_cyc.size() - 1], 2);
        end else begin
            check("strobes_seen", stb_cyc.size(), 2);
        end
        check("done_with_busy_low", done_busy, 0);
        check("full_adjacent_strobes", adj_viol, 0);

        // Backpressure on random contents, ignored start, then reset inside row 3
        for (int i = 0; i < (1 << RAM_BITS); i++) mem[i] = 8'($urandom);
        build_exp();
        got.delete();
        stb_cyc.delete();
        hold = 10;
        d0   = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_bytes("bp_reach_100", 100, 5000);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_ignored_start", int'(busy), 1);
        wait_bytes("bp_reach_row3", 3 * LPL + 40, 10000);
        rst = 1'b1;
        tick();
        check_all_zero("reset_mid");
        n_rst = got.size();
        rst = 1'b0;
        check("bp_prefix_mismatches", stream_mism(n_rst), 0);
        repeat (60) tick();
        check("no_stb_after_reset", got.size(), n_rst);
        check("no_done_after_reset", done_cnt, d0);
        check("stb_while_busy", busy_viol, 0);
        check("adjacent_strobes", adj_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
